// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_unit
// Description : Program counter and next-address select for the IM fetch
//               stage, with a retired-fetch counter and a sticky fault trap.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned IM_DEPTH_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic        jal,
    input  logic        jalr,
    input  logic [31:0] imm,
    input  logic [31:0] rs1_data,
    output logic [31:0] addrIM,
    output logic [31:0] pc_plus4,
    output logic [31:0] inst_count,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic [31:0] trap_addr
);

    // Upper bound held in 33 bits so a range ending at 2^32 cannot wrap.
    localparam logic [32:0] c_IM_END = {1'b0, RESET_PC} + (33'(IM_DEPTH_WORDS) << 2);

    localparam logic [1:0] c_CAUSE_NONE      = 2'b00;
    localparam logic [1:0] c_CAUSE_MISALIGN  = 2'b01;
    localparam logic [1:0] c_CAUSE_OUT_RANGE = 2'b10;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_TRAP = 1'b1
    } state_t;

    state_t      r_state_q,      w_state_d;
    logic [31:0] r_pc_q,         w_pc_d;
    logic [31:0] r_count_q,      w_count_d;
    logic [1:0]  r_cause_q,      w_cause_d;
    logic [31:0] r_taddr_q,      w_taddr_d;

    logic [31:0] w_seq_target;
    logic [31:0] w_rel_target;
    logic [31:0] w_jalr_target;
    logic [31:0] w_candidate;
    logic        w_misaligned;
    logic        w_out_of_range;

    assign w_seq_target  = r_pc_q + 32'd4;
    assign w_rel_target  = r_pc_q + imm;
    assign w_jalr_target = (rs1_data + imm) & ~32'h1;

    always_comb begin
        w_candidate = w_seq_target;
        if (jalr) begin
            w_candidate = w_jalr_target;
        end else if (jal || branch_taken) begin
            w_candidate = w_rel_target;
        end
    end

    assign w_misaligned   = |w_candidate[1:0];
    assign w_out_of_range = (w_candidate < RESET_PC) || ({1'b0, w_candidate} >= c_IM_END);

    always_comb begin
        w_state_d = r_state_q;
        w_pc_d    = r_pc_q;
        w_count_d = r_count_q;
        w_cause_d = r_cause_q;
        w_taddr_d = r_taddr_q;
        case (r_state_q)
            ST_RUN: begin
                if (!stall) begin
                    if (w_misaligned || w_out_of_range) begin
                        // PC stays on the faulting instruction for diagnosis.
                        w_state_d = ST_TRAP;
                        w_cause_d = w_misaligned ? c_CAUSE_MISALIGN : c_CAUSE_OUT_RANGE;
                        w_taddr_d = w_candidate;
                    end else begin
                        w_pc_d    = w_candidate;
                        w_count_d = r_count_q + 32'd1;
                    end
                end
            end
            ST_TRAP: begin
                w_state_d = ST_TRAP;
            end
            default: begin
                w_state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= ST_RUN;
            r_pc_q    <= RESET_PC;
            r_count_q <= 32'd0;
            r_cause_q <= c_CAUSE_NONE;
            r_taddr_q <= 32'd0;
        end else begin
            r_state_q <= w_state_d;
            r_pc_q    <= w_pc_d;
            r_count_q <= w_count_d;
            r_cause_q <= w_cause_d;
            r_taddr_q <= w_taddr_d;
        end
    end

    assign addrIM     = r_pc_q;
    assign pc_plus4   = w_seq_target;
    assign inst_count = r_count_q;
    assign trap       = (r_state_q == ST_TRAP);
    assign trap_cause = r_cause_q;
    assign trap_addr  = r_taddr_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_fetch_unit
// Description : Directed vector bench for pc_fetch_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic        jal = 1'b0;
    logic        jalr = 1'b0;
    logic [31:0] imm = 32'd0;
    logic [31:0] rs1_data = 32'd0;
    logic [31:0] addrIM;
    logic [31:0] pc_plus4;
    logic [31:0] inst_count;
    logic        trap;
    logic [1:0]  trap_cause;
    logic [31:0] trap_addr;

    int checks = 0;
    int errors = 0;

    pc_fetch_unit #(
        .RESET_PC       (32'h0000_0000),
        .IM_DEPTH_WORDS (64)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .branch_taken (branch_taken),
        .jal          (jal),
        .jalr         (jalr),
        .imm          (imm),
        .rs1_data     (rs1_data),
        .addrIM       (addrIM),
        .pc_plus4     (pc_plus4),
        .inst_count   (inst_count),
        .trap         (trap),
        .trap_cause   (trap_cause),
        .trap_addr    (trap_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        br;
        logic        jal;
        logic        jalr;
        logic [31:0] imm;
        logic [31:0] rs1;
        logic [31:0] pc;
        logic [31:0] cnt;
        logic        trap;
        logic [1:0]  cause;
        logic [31:0] taddr;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic s, input logic b, input logic j,
                       input logic jr, input logic [31:0] im, input logic [31:0] rs,
                       input logic [31:0] pc, input logic [31:0] cnt, input logic tr,
                       input logic [1:0] ca, input logic [31:0] ta);
        vec_t v;
        v.rst = r; v.stall = s; v.br = b; v.jal = j; v.jalr = jr;
        v.imm = im; v.rs1 = rs; v.pc = pc; v.cnt = cnt;
        v.trap = tr; v.cause = ca; v.taddr = ta;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] pc, input logic [31:0] cnt,
                             input logic tr, input logic [1:0] ca, input logic [31:0] ta);
        check({tag, " addrIM"},     addrIM,             pc);
        check({tag, " pc_plus4"},   pc_plus4,           pc + 32'd4);
        check({tag, " inst_count"}, inst_count,         cnt);
        check({tag, " trap"},       {31'd0, trap},      {31'd0, tr});
        check({tag, " trap_cause"}, {30'd0, trap_cause}, {30'd0, ca});
        check({tag, " trap_addr"},  trap_addr,          ta);
    endtask

    task automatic drive(input logic r, input logic s, input logic b, input logic j,
                         input logic jr, input logic [31:0] im, input logic [31:0] rs);
        rst = r; stall = s; branch_taken = b; jal = j; jalr = jr; imm = im; rs1_data = rs;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //   rst s br jal jalr imm            rs1           pc            cnt tr cause taddr
        add(1, 0, 0, 0, 0, 32'h0,          32'h0,        32'h00,       0, 0, 2'd0, 32'h0);
        for (int i = 1; i <= 5; i++)
            add(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'(4 * i), 32'(i), 0, 2'd0, 32'h0);
        add(1, 0, 0, 0, 0, 32'h0,          32'h0,        32'h00,       0, 0, 2'd0, 32'h0);
        for (int i = 1; i <= 4; i++)
            add(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'(4 * i), 32'(i), 0, 2'd0, 32'h0);
        add(0, 0, 1, 0, 0, 32'hFFFF_FFF8,  32'h0,        32'h08,       5, 0, 2'd0, 32'h0);
        add(0, 0, 1, 1, 0, 32'h20,         32'h0,        32'h28,       6, 0, 2'd0, 32'h0);
        add(0, 0, 0, 0, 1, 32'h4,          32'h31,       32'h34,       7, 0, 2'd0, 32'h0);
        add(0, 0, 0, 0, 1, 32'h0,          32'h32,       32'h34,       7, 1, 2'd1, 32'h32);
        add(0, 1, 0, 1, 0, 32'h40,         32'h0,        32'h34,       7, 1, 2'd1, 32'h32);
        add(0, 0, 0, 0, 1, 32'h0,          32'h0,        32'h34,       7, 1, 2'd1, 32'h32);
        add(1, 0, 0, 1, 0, 32'h40,         32'h0,        32'h00,       0, 0, 2'd0, 32'h0);
        add(0, 0, 0, 0, 0, 32'h0,          32'h0,        32'h04,       1, 0, 2'd0, 32'h0);
        add(0, 0, 0, 0, 0, 32'h0,          32'h0,        32'h08,       2, 0, 2'd0, 32'h0);
        for (int i = 0; i < 3; i++)
            add(0, 1, 0, 1, 0, 32'h40, 32'h0, 32'h08, 2, 0, 2'd0, 32'h0);
        add(0, 0, 0, 1, 0, 32'h40,         32'h0,        32'h48,       3, 0, 2'd0, 32'h0);
        add(1, 1, 0, 1, 0, 32'h40,         32'h0,        32'h00,       0, 0, 2'd0, 32'h0);
        add(0, 0, 0, 1, 0, 32'hFC,         32'h0,        32'hFC,       1, 0, 2'd0, 32'h0);
        add(0, 0, 0, 0, 0, 32'h0,          32'h0,        32'hFC,       1, 1, 2'd2, 32'h100);
        for (int i = 0; i < 3; i++)
            add(0, 0, 0, 1, 0, 32'h8, 32'h0, 32'hFC, 1, 1, 2'd2, 32'h100);
        add(1, 0, 0, 0, 0, 32'h0,          32'h0,        32'h00,       0, 0, 2'd0, 32'h0);
        add(0, 0, 0, 1, 0, 32'h102,        32'h0,        32'h00,       0, 1, 2'd1, 32'h102);
        add(1, 0, 0, 0, 0, 32'h0,          32'h0,        32'h00,       0, 0, 2'd0, 32'h0);
        add(0, 0, 0, 1, 0, 32'hFFFF_FFFC,  32'h0,        32'h00,       0, 1, 2'd2, 32'hFFFF_FFFC);
        add(1, 0, 0, 0, 0, 32'h0,          32'h0,        32'h00,       0, 0, 2'd0, 32'h0);
        add(0, 0, 0, 1, 1, 32'h4,          32'h20,       32'h24,       1, 0, 2'd0, 32'h0);

        @(negedge clk);
        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].stall, vecs[i].br, vecs[i].jal, vecs[i].jalr,
                  vecs[i].imm, vecs[i].rs1);
            check_all($sformatf("vec%0d", i), vecs[i].pc, vecs[i].cnt, vecs[i].trap,
                      vecs[i].cause, vecs[i].taddr);
        end

        // Long stall with shifting control inputs must not move PC or count.
        for (int i = 0; i < 10; i++) begin
            drive(0, 1, i[0], i[1], i[2], 32'($urandom_range(0, 15)) << 2, 32'h10);
            check_all($sformatf("stall%0d", i), 32'h24, 32'd1, 1'b0, 2'd0, 32'h0);
        end
        drive(0, 0, 0, 0, 0, 32'h0, 32'h0);
        check_all("release", 32'h28, 32'd2, 1'b0, 2'd0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
